// File: rtl/multi_bit_syn_filt.sv
// rtl/multi_bit_syn_filt.sv - bank of independent multi-flop synchronizers with per-bit glitch filter
// and registered rise/fall/any-change pulses.

module multi_bit_syn_filt #(
  parameter int                   BUS_WIDTH  = 4,
  parameter int                   NUM_STAGES = 2,
  parameter int                   FILT_CNT   = 3,
  parameter logic [BUS_WIDTH-1:0] RST_VAL    = {BUS_WIDTH{1'b0}}
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] RISE,
  output logic [BUS_WIDTH-1:0] FALL,
  output logic                 CHG
);

  localparam int               CNT_W    = $clog2(FILT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

  logic [BUS_WIDTH-1:0] r_chain [NUM_STAGES];
  logic [CNT_W-1:0]     r_cnt   [BUS_WIDTH];
  logic [BUS_WIDTH-1:0] r_sync;
  logic [BUS_WIDTH-1:0] r_rise;
  logic [BUS_WIDTH-1:0] r_fall;
  logic                 r_chg;

  logic [BUS_WIDTH-1:0] w_s;
  logic [BUS_WIDTH-1:0] w_diff;
  logic [BUS_WIDTH-1:0] w_upd;

  // Plain flop chain: stage 0 is the only capture point for the asynchronous input.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_chain[k] <= RST_VAL;
      end
    end else begin
      r_chain[0] <= ASYNC;
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
    end
  end

  assign w_s    = r_chain[NUM_STAGES-1];
  assign w_diff = w_s ^ r_sync;

  always_comb begin
    w_upd = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      w_upd[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
    end
  end

  // The counter only advances while the synced level disagrees with SYNC, so any return clears it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < BUS_WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
      r_sync <= RST_VAL;
      r_rise <= '0;
      r_fall <= '0;
      r_chg  <= 1'b0;
    end else begin
      for (int i = 0; i < BUS_WIDTH; i++) begin
        if (!w_diff[i] || w_upd[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      r_sync <= r_sync ^ w_upd;
      r_rise <= w_upd & w_s;
      r_fall <= w_upd & ~w_s;
      r_chg  <= |w_upd;
    end
  end

  assign SYNC = r_sync;
  assign RISE = r_rise;
  assign FALL = r_fall;
  assign CHG  = r_chg;

endmodule
